// File: rtl/mdio_responder.sv
// mdio_responder: Clause 22 MDIO responder bridging MDIO frames to a simple register port
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR      = 5'd1,
  parameter int         PREAMBLE_BITS = 32,
  parameter int         SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic [4:0]  reg_addr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  output logic        reg_wr,
  output logic [15:0] reg_wdata,
  output logic        busy
);
  typedef enum logic [3:0] {IDLE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA, SKIP} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] mdc_sr, mdio_sr;
  logic        mdc_d, rise, din, is_rd, rd_d;
  logic [5:0]  pcnt;
  logic [4:0]  cnt;
  logic [15:0] sh, sh_n, rdata;
  assign rise = mdc_sr[SYNC_STAGES-1] & ~mdc_d;
  assign din  = mdio_sr[SYNC_STAGES-1];
  assign sh_n = {sh[14:0], din};
  // synchronise mdc/mdio; idle-high reset avoids a spurious rise after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mdc_sr  <= '1;
      mdio_sr <= '1;
      mdc_d   <= 1'b1;
    end else begin
      mdc_sr  <= {mdc_sr[SYNC_STAGES-2:0], mdc};
      mdio_sr <= {mdio_sr[SYNC_STAGES-2:0], mdio_i};
      mdc_d   <= mdc_sr[SYNC_STAGES-1];
    end
  // frame decoder; all bit handling happens on a synchronised mdc rise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      pcnt      <= '0;
      cnt       <= '0;
      sh        <= '0;
      is_rd     <= 1'b0;
      rd_d      <= 1'b0;
      rdata     <= '0;
      mdio_o    <= 1'b1;
      mdio_t    <= 1'b1;
      reg_addr  <= '0;
      reg_rd    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      reg_rd <= 1'b0;
      reg_wr <= 1'b0;
      rd_d   <= reg_rd;
      if (rd_d) rdata <= reg_rdata;
      if (rise) begin
        sh  <= sh_n;
        cnt <= cnt + 5'd1;
        case (state)
          IDLE: begin
            cnt <= '0;
            if (din) pcnt <= (pcnt == 6'd63) ? pcnt : pcnt + 6'd1;
            else if (pcnt >= 6'(PREAMBLE_BITS)) begin
              state <= ST;
              busy  <= 1'b1;
              pcnt  <= '0;
            end else pcnt <= '0;
          end
          ST: begin
            cnt   <= '0;
            state <= din ? OP : IDLE;
            busy  <= din;
          end
          OP: if (cnt == 5'd1) begin
            cnt   <= '0;
            is_rd <= sh[0];
            state <= (sh[0] ^ din) ? PHYAD : IDLE;
            busy  <= sh[0] ^ din;
          end
          PHYAD: if (cnt == 5'd4) begin
            cnt   <= '0;
            state <= REGAD;
          end
          REGAD: if (cnt == 5'd4) begin
            cnt <= '0;
            if (sh[8:4] == PHY_ADDR) begin
              reg_addr <= sh_n[4:0];
              reg_rd   <= is_rd;
              state    <= TA;
            end else state <= SKIP;
          end
          TA: if (is_rd) begin
            cnt    <= '0;
            mdio_t <= 1'b0;
            mdio_o <= 1'b0;
            state  <= RDATA;
          end else if (cnt == 5'd1) begin
            cnt   <= '0;
            state <= WDATA;
          end
          RDATA: if (cnt == 5'd16) begin
            mdio_t <= 1'b1;
            mdio_o <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else mdio_o <= rdata[4'd15 - cnt[3:0]];
          WDATA: if (cnt == 5'd15) begin
            reg_wdata <= sh_n;
            reg_wr    <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
          SKIP: if (cnt == 5'd17) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            mdio_t <= 1'b1;
            mdio_o <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: directed MDIO frames with a queue-based scoreboard
module tb_mdio_responder;
  logic clk = 0, rst_n = 0, mdc = 1, mdio_i = 1;
  logic mdio_o, mdio_t, reg_rd, reg_wr, busy;
  logic [4:0] reg_addr;
  logic [15:0] reg_rdata = 16'h0, reg_wdata;
  int n_vec = 0, n_err = 0, half = 5;
  typedef struct {logic [1:0] k; logic [4:0] a; logic [31:0] d;} item_t;
  item_t q[$];
  mdio_responder #(.PHY_ADDR(5'd1), .PREAMBLE_BITS(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .mdc(mdc), .mdio_i(mdio_i), .mdio_o(mdio_o), .mdio_t(mdio_t),
    .reg_addr(reg_addr), .reg_rd(reg_rd), .reg_rdata(reg_rdata), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .busy(busy));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic sb_pop(input logic [1:0] k, input logic [4:0] a, input logic [31:0] d);
    item_t e;
    if (q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_event: got kind %0d addr %h data %h want none", k, a, d);
    end else begin
      e = q.pop_front();
      chk("sb_kind", 32'(k), 32'(e.k));
      chk("sb_addr", 32'(a), 32'(e.a));
      chk("sb_data", d, e.d);
    end
  endtask
  task automatic exp_rd(input logic [4:0] a, input logic [15:0] d);
    q.push_back('{2'd1, a, 32'h0});
    q.push_back('{2'd3, 5'd0, {15'd17, 1'b0, d}});
  endtask
  task automatic exp_wr(input logic [4:0] a, input logic [15:0] d);
    q.push_back('{2'd2, a, {16'h0, d}});
  endtask
  logic mdc_q = 1, t_q = 1;
  logic [16:0] rsh = '0;
  int rn = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      rn = 0;
      t_q = 1;
    end else begin
      if (reg_rd) sb_pop(2'd1, reg_addr, 32'h0);
      if (reg_wr) sb_pop(2'd2, reg_addr, {16'h0, reg_wdata});
      if (mdc && !mdc_q && !mdio_t) begin
        rsh = {rsh[15:0], mdio_o};
        rn++;
      end
      if (mdio_t && !t_q) begin
        sb_pop(2'd3, 5'd0, {15'(rn), rsh});
        rn = 0;
      end
      t_q = mdio_t;
    end
    mdc_q = mdc;
  end
  task automatic mbit(input logic b);
    @(posedge clk); #1;
    mdc = 0;
    mdio_i = b;
    repeat (half) @(posedge clk);
    #1 mdc = 1;
    repeat (half) @(posedge clk);
  endtask
  task automatic pre(input int n);
    repeat (n) mbit(1'b1);
  endtask
  task automatic frame(input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd, input int nbits, input logic exp_busy);
    logic [31:0] bits;
    bits = {2'b01, op, pa, ra, (op == 2'b01) ? 2'b10 : 2'b11, (op == 2'b01) ? wd : 16'hFFFF};
    for (int i = 0; i < nbits; i++) begin
      mbit(bits[31-i]);
      if (i == 19) chk("busy_mid", 32'(busy), 32'(exp_busy));
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mdio_t", 32'(mdio_t), 32'd1);
    chk("rst_mdio_o", 32'(mdio_o), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("rst_reg_wdata", 32'(reg_wdata), 32'd0);
    chk("rst_strobes", {30'd0, reg_rd, reg_wr}, 32'd0);
    rst_n = 1;
    reg_rdata = 16'hA5C3;
    exp_rd(5'd2, 16'hA5C3);
    pre(32); frame(2'b10, 5'd1, 5'd2, 16'h0, 32, 1'b1);
    chk("rd_reg_addr", 32'(reg_addr), 32'd2);
    chk("rd_busy_end", 32'(busy), 32'd0);
    exp_wr(5'd31, 16'h1234);
    pre(32); frame(2'b01, 5'd1, 5'd31, 16'h1234, 32, 1'b1);
    chk("wr_reg_wdata", 32'(reg_wdata), 32'h1234);
    pre(32); frame(2'b10, 5'd3, 5'd5, 16'h0, 32, 1'b1);
    chk("skip_busy_end", 32'(busy), 32'd0);
    chk("skip_reg_addr", 32'(reg_addr), 32'd31);
    reg_rdata = 16'h0F0F;
    exp_rd(5'd7, 16'h0F0F);
    pre(32); frame(2'b10, 5'd1, 5'd7, 16'h0, 32, 1'b1);
    pre(31); frame(2'b10, 5'd1, 5'd3, 16'h0, 32, 1'b0);
    chk("short_pre_addr", 32'(reg_addr), 32'd7);
    pre(32); frame(2'b11, 5'd1, 5'd3, 16'h0, 32, 1'b0);
    chk("op11_busy", 32'(busy), 32'd0);
    exp_wr(5'd4, 16'hBEEF);
    pre(32); frame(2'b01, 5'd1, 5'd4, 16'hBEEF, 32, 1'b1);
    reg_rdata = 16'h5555;
    q.push_back('{2'd1, 5'd9, 32'h0});
    pre(32); frame(2'b10, 5'd1, 5'd9, 16'h0, 25, 1'b1);
    chk("drv_before_rst", 32'(mdio_t), 32'd0);
    rst_n = 0;
    #1;
    chk("rst_mid_mdio_t", 32'(mdio_t), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_addr", 32'(reg_addr), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    reg_rdata = 16'h8001;
    exp_rd(5'd9, 16'h8001);
    pre(32); frame(2'b10, 5'd1, 5'd9, 16'h0, 32, 1'b1);
    half = 4;
    exp_wr(5'd10, 16'h0001);
    exp_wr(5'd11, 16'hFFFE);
    pre(32); frame(2'b01, 5'd1, 5'd10, 16'h0001, 32, 1'b1);
    pre(32); frame(2'b01, 5'd1, 5'd11, 16'hFFFE, 32, 1'b1);
    chk("b2b_wdata", 32'(reg_wdata), 32'hFFFE);
    repeat (20) @(posedge clk);
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
